// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch front end: field constants,
// the prefetch queue entry and the j/jal target helper.
package ifetch_pkg;

   localparam int          INSTR_W     = 32;
   localparam int          JTARGET_LSB = 0;
   localparam int          JTARGET_W   = 26;
   localparam logic [31:0] PC_INC      = 32'd4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
   } fetch_entry_t;

   // Pseudo-direct jump: keep the PC's top nibble, splice in the word index.
   function automatic logic [31:0] jump_target(input logic [31:0]        pc,
                                               input logic [INSTR_W-1:0] instr);
      return {pc[31:28], instr[JTARGET_LSB +: JTARGET_W], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Bus bundle between the fetch unit (master) and its ROM/decode environment (slave).
interface ifetch_prefetch_if #(
   parameter int ADDR_W = 14
);
   import ifetch_pkg::*;

   logic               imem_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [31:0]        out_pc;
   logic [31:0]        branch_base_addr;
   logic [31:0]        link_addr;
   logic [31:0]        addr_result;
   logic [31:0]        read_data_1;
   logic               branch;
   logic               nbranch;
   logic               jmp;
   logic               jal;
   logic               jr;
   logic               zero;

   modport master (
      output imem_en, imem_addr, out_valid, out_instr, out_pc,
             branch_base_addr, link_addr,
      input  imem_data, out_ready, addr_result, read_data_1,
             branch, nbranch, jmp, jal, jr, zero
   );

   modport slave (
      input  imem_en, imem_addr, out_valid, out_instr, out_pc,
             branch_base_addr, link_addr,
      output imem_data, out_ready, addr_result, read_data_1,
             branch, nbranch, jmp, jal, jr, zero
   );

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry prefetch queue of {instr, pc}; flush wins over push/pop.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  fetch_entry_t     i_data,
   output fetch_entry_t     o_head,
   output logic [CNT_W-1:0] o_count
);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop && (r_count != {CNT_W{1'b0}});
   assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else if (i_flush) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Storage is cleared on reset so the head reads zero before the first push.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential ROM requests into a tagged prefetch
// queue, valid/ready hand-off to decode, redirect resolution on the consumed head.
module ifetch_prefetch
   import ifetch_pkg::*;
#(
   parameter int          ADDR_W   = 14,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                 clock,
   input logic                 reset,
   ifetch_prefetch_if.master   bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      r_fpc;
   logic [31:0]      r_issue_pc;
   logic             r_inflight;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W:0]   w_occupancy;
   fetch_entry_t     w_head;
   fetch_entry_t     w_push_data;
   logic             w_valid;
   logic             w_fire;
   logic             w_issue;
   logic             w_push;
   logic             w_redirect;
   logic [31:0]      w_target_raw;
   logic [31:0]      w_target;

   assign w_valid     = (w_count != {CNT_W{1'b0}});
   assign w_fire      = w_valid && bus.out_ready;
   // The outstanding request is counted so the queue can never overflow.
   assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue     = !reset && !w_redirect && (w_occupancy < (CNT_W+1)'(DEPTH));
   // A response landing in the redirect cycle belongs to the squashed path.
   assign w_push      = r_inflight && !w_redirect;
   assign w_push_data = {bus.imem_data, r_issue_pc};
   assign w_target    = {w_target_raw[31:2], 2'b00};

   always_comb begin
      w_redirect   = 1'b0;
      w_target_raw = 32'h0000_0000;
      if (!w_fire) begin
         w_redirect = 1'b0;
      end else if (bus.jmp || bus.jal) begin
         w_redirect   = 1'b1;
         w_target_raw = jump_target(w_head.pc, w_head.instr);
      end else if ((bus.branch && bus.zero) || (bus.nbranch && !bus.zero)) begin
         w_redirect   = 1'b1;
         w_target_raw = bus.addr_result;
      end else if (bus.jr) begin
         w_redirect   = 1'b1;
         w_target_raw = bus.read_data_1;
      end else begin
         w_redirect = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fpc      <= RESET_PC;
         r_issue_pc <= 32'h0000_0000;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_redirect) begin
            r_fpc <= w_target;
         end else if (w_issue) begin
            r_fpc      <= r_fpc + PC_INC;
            r_issue_pc <= r_fpc;
         end
      end
   end

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_fire),
      .i_flush (w_redirect),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign bus.imem_en          = w_issue;
   assign bus.imem_addr        = r_fpc[ADDR_W+1:2];
   assign bus.out_valid        = w_valid;
   assign bus.out_instr        = w_head.instr;
   assign bus.out_pc           = w_head.pc;
   assign bus.branch_base_addr = w_head.pc + PC_INC;
   assign bus.link_addr        = w_head.pc + PC_INC;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: redirect vector table, hand-written
// stream/stall/reset sequences, and a randomized run against a program-order model.
module tb_ifetch_prefetch;
   import ifetch_pkg::*;

   localparam int          ADDR_W   = 14;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          ROM_N    = 1 << ADDR_W;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] rom [ROM_N];
   int          n_cmp = 0;
   int          n_bad = 0;

   ifetch_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

   ifetch_prefetch #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Synchronous ROM: word appears the cycle after the request.
   always @(posedge clock) begin
      if (bus.imem_en) bus.imem_data <= rom[bus.imem_addr];
   end

   typedef struct {
      logic [31:0] start_pc;
      logic [31:0] instr;
      logic        br, nbr, jm, jl, jrr, z;
      logic [31:0] ar, rd1;
      logic [31:0] exp_pc;
      int          exp_lat;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rom_at(input logic [31:0] pc);
      return rom[pc[ADDR_W+1:2]];
   endfunction

   // Program-order successor of a consumed instruction, straight from the redirect rules.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                              input logic br, input logic nbr, input logic jm,
                                              input logic jl, input logic jrr, input logic z,
                                              input logic [31:0] ar, input logic [31:0] rd1);
      logic [31:0] t;
      if (jm || jl)                  t = {pc[31:28], instr[25:0], 2'b00};
      else if ((br && z) || (nbr && !z)) t = ar;
      else if (jrr)                  t = rd1;
      else                           t = pc + 32'd4;
      return t & 32'hFFFF_FFFC;
   endfunction

   task automatic set_ctrl(input logic br, input logic nbr, input logic jm, input logic jl,
                           input logic jrr, input logic z, input logic [31:0] ar,
                           input logic [31:0] rd1, input logic rdy);
      bus.branch = br; bus.nbranch = nbr; bus.jmp = jm; bus.jal = jl;
      bus.jr = jrr; bus.zero = z; bus.addr_result = ar; bus.read_data_1 = rd1;
      bus.out_ready = rdy;
   endtask

   task automatic clear_ctrl();
      set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      clear_ctrl();
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Waits (ready low unless caller set it) for a valid head; bounded.
   task automatic wait_valid(input int limit, output int waited);
      waited = 0;
      while (waited < limit) begin
         @(negedge clock); #1;
         waited++;
         if (bus.out_valid) break;
      end
   endtask

   // Consume the current head with the given controls, then drop everything.
   task automatic fire_head(input logic br, input logic nbr, input logic jm, input logic jl,
                            input logic jrr, input logic z, input logic [31:0] ar,
                            input logic [31:0] rd1);
      set_ctrl(br, nbr, jm, jl, jrr, z, ar, rd1, 1'b1);
      @(posedge clock); #1;
      clear_ctrl();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          w;
      int          bubble;
      logic [31:0] exp_pc;
      logic        rb, rnb, rjm, rjl, rjr, rz, rrdy;
      logic [31:0] rar, rrd;

      for (int k = 0; k < ROM_N; k++) rom[k] = k;
      reset = 1'b1;
      clear_ctrl();

      // Reset state
      @(negedge clock); #1;
      check("rst out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rst imem_en",   {31'h0, bus.imem_en},   32'h0);
      check("rst out_pc",    bus.out_pc,              32'h0);
      check("rst out_instr", bus.out_instr,           32'h0);

      // Sequence A: streaming from reset, one instruction per cycle from cycle 2
      @(negedge clock);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clock); #1;
      check("A valid cycle1", {31'h0, bus.out_valid}, 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock); #1;
         check($sformatf("A valid %0d", k), {31'h0, bus.out_valid}, 32'h1);
         check($sformatf("A pc %0d", k),    bus.out_pc,    32'(4 * k));
         check($sformatf("A instr %0d", k), bus.out_instr, 32'(k));
      end

      // Sequence B: stall 10 cycles, queue fills and fetch stops, then resume
      @(negedge clock);
      bus.out_ready = 1'b0;
      repeat (10) @(negedge clock);
      #1;
      check("B imem_en full", {31'h0, bus.imem_en},   32'h0);
      check("B valid full",   {31'h0, bus.out_valid}, 32'h1);
      bus.out_ready = 1'b1;
      for (int k = 8; k < 16; k++) begin
         check($sformatf("B pc %0d", k),    bus.out_pc,    32'(4 * k));
         check($sformatf("B instr %0d", k), bus.out_instr, 32'(k));
         @(negedge clock); #1;
      end

      // Sequence C: reset with three queued entries and one request in flight
      do_reset();
      repeat (4) @(negedge clock);
      reset = 1'b1;
      #1;
      check("C valid in reset",   {31'h0, bus.out_valid}, 32'h0);
      check("C imem_en in reset", {31'h0, bus.imem_en},   32'h0);
      #1;
      reset = 1'b0;
      bus.out_ready = 1'b1;
      wait_valid(6, w);
      check("C restart latency", 32'(w), 32'd2);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("C pc %0d", k),    bus.out_pc,    32'(4 * k));
         check($sformatf("C instr %0d", k), bus.out_instr, 32'(k));
         @(negedge clock); #1;
      end
      clear_ctrl();

      // Redirect vector table: {start pc, head instr, br,nbr,jmp,jal,jr,zero, addr_result, read_data_1, next pc, latency}
      vecs[0] = '{32'h1000_0020, {6'h03, 26'h10}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   32'h1000_0040, 3};
      vecs[1] = '{32'h0000_0100, {6'h02, 26'h80}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40,  32'h0,   32'h0000_0200, 3};
      vecs[2] = '{32'h0000_0050, 32'h0000_0008,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h33,  32'h0000_0030, 3};
      vecs[3] = '{32'h0000_0010, {6'h04, 26'h0},  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  32'h0,   32'h0000_0040, 3};
      vecs[4] = '{32'h0000_0200, {6'h05, 26'h0},  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h88,  32'h0,   32'h0000_0088, 3};
      vecs[5] = '{32'h0000_0300, {6'h04, 26'h0},  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0,   32'h0000_0304, 1};
      vecs[6] = '{32'h0000_0400, {6'h05, 26'h0},  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'h0,   32'h0000_0404, 1};
      vecs[7] = '{32'h0000_0060, {6'h04, 26'h0},  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h47,  32'h900, 32'h0000_0044, 3};
      vecs[8] = '{32'h0000_0700, 32'h1234_5678,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  32'h80,  32'h0000_0704, 1};
      vecs[9] = '{32'hFFFF_FFFC, 32'h0000_0000,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0000_0000, 1};

      for (int i = 0; i < 10; i++) begin
         rom[vecs[i].start_pc[ADDR_W+1:2]] = vecs[i].instr;
         do_reset();
         wait_valid(8, w);
         check($sformatf("V%0d reset latency", i), 32'(w), 32'd2);
         fire_head(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, vecs[i].start_pc);
         wait_valid(8, w);
         check($sformatf("V%0d jr latency", i),  32'(w),               32'd3);
         check($sformatf("V%0d head pc", i),     bus.out_pc,           vecs[i].start_pc);
         check($sformatf("V%0d head instr", i),  bus.out_instr,        vecs[i].instr);
         check($sformatf("V%0d link_addr", i),   bus.link_addr,        vecs[i].start_pc + 32'd4);
         check($sformatf("V%0d branch_base", i), bus.branch_base_addr, vecs[i].start_pc + 32'd4);
         fire_head(vecs[i].br, vecs[i].nbr, vecs[i].jm, vecs[i].jl, vecs[i].jrr, vecs[i].z,
                   vecs[i].ar, vecs[i].rd1);
         wait_valid(8, w);
         check($sformatf("V%0d next latency", i), 32'(w),        32'(vecs[i].exp_lat));
         check($sformatf("V%0d next pc", i),      bus.out_pc,    vecs[i].exp_pc);
         check($sformatf("V%0d next instr", i),   bus.out_instr, rom_at(vecs[i].exp_pc));
         rom[vecs[i].start_pc[ADDR_W+1:2]] = vecs[i].start_pc[ADDR_W+1:2];
      end

      // Randomized run against the program-order model
      for (int k = 0; k < ROM_N; k++) rom[k] = $urandom;
      do_reset();
      exp_pc = RESET_PC;
      bubble = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         rrdy = ($urandom_range(0, 9) < 7);
         rjm  = ($urandom_range(0, 15) == 0);
         rjl  = ($urandom_range(0, 15) == 0);
         rb   = ($urandom_range(0, 3) == 0);
         rnb  = ($urandom_range(0, 3) == 0);
         rjr  = ($urandom_range(0, 7) == 0);
         rz   = 1'($urandom_range(0, 1));
         rar  = $urandom;
         rrd  = $urandom;
         set_ctrl(rb, rnb, rjm, rjl, rjr, rz, rar, rrd, rrdy);
         #1;
         if (bus.out_valid && rrdy) begin
            check("R pc",    bus.out_pc,    exp_pc);
            check("R instr", bus.out_instr, rom_at(exp_pc));
            check("R link",  bus.link_addr, exp_pc + 32'd4);
            exp_pc = model_next(exp_pc, rom_at(exp_pc), rb, rnb, rjm, rjl, rjr, rz, rar, rrd);
         end
         if (bus.out_valid) begin
            bubble = 0;
         end else if (rrdy) begin
            bubble++;
            if (bubble > 2) begin
               check("R bubble run", 32'(bubble), 32'd2);
               bubble = 0;
            end
         end
      end
      clear_ctrl();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
